// File: rtl/dtc_share_ctrl_pkg.sv
// Shared types and default widths for the decision-tree classifier share controller.
package dtc_pkg;

  localparam int FEAT_W  = 8;
  localparam int CLS_W   = 2;
  localparam int N_CLASS = 2 ** CLS_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dtc_share_ctrl_if.sv
// Request/response handshake bundle between requesters, response consumer and the share controller.
interface dtc_share_ctrl_if #(
  parameter int N_REQ  = 4,
  parameter int FEAT_W = 8,
  parameter int CLS_W  = 2
);

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*FEAT_W-1:0] req_feat;
  logic [N_REQ-1:0]        req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [CLS_W-1:0]        rsp_class;

  modport master (
    output req_valid, req_feat, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_class
  );

  modport slave (
    input  req_valid, req_feat, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_class
  );

endinterface

// File: rtl/dtc_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/dtc_share_ctrl.sv
// Time-shares one external combinational classifier among N_REQ requesters, round-robin,
// and keeps saturating per-class response counters.
module dtc_share_ctrl #(
  parameter int N_REQ  = 4,
  parameter int FEAT_W = dtc_pkg::FEAT_W,
  parameter int CLS_W  = dtc_pkg::CLS_W,
  parameter int CNT_W  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  dtc_share_ctrl_if.slave                 bus,
  output logic [FEAT_W-1:0]               cls_feat,
  input  logic [CLS_W-1:0]                cls_class,
  input  logic                            cnt_clear,
  output logic [(2**CLS_W)*CNT_W-1:0]     class_count,
  output logic                            busy
);

  import dtc_pkg::*;

  localparam int ID_W = $clog2(N_REQ);
  localparam int NCLS = 2 ** CLS_W;

  state_e            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [FEAT_W-1:0] cls_feat_q;
  logic [CLS_W-1:0]  rsp_class_q;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_id;
  logic              rsp_fire;
  logic [CNT_W-1:0]  cnt_q [NCLS];
  logic [CNT_W-1:0]  cnt_d [NCLS];

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req      (bus.req_valid),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // Grant is only offered while idle, so rsp_ready never reaches req_ready.
  assign bus.req_ready = (state_q == ST_IDLE) ? grant : '0;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_class = rsp_class_q;
  assign cls_feat      = cls_feat_q;
  assign busy          = (state_q != ST_IDLE);
  assign rsp_fire      = (state_q == ST_RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      rsp_id_q    <= '0;
      cls_feat_q  <= '0;
      rsp_class_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            cls_feat_q <= bus.req_feat[int'(grant_id)*FEAT_W +: FEAT_W];
            rsp_id_q   <= grant_id;
            state_q    <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          rsp_class_q <= cls_class;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rr_ptr_q <= (int'(rsp_id_q) == N_REQ - 1) ? '0 : rsp_id_q + ID_W'(1);
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Clear beats a coincident increment; counters stick at all-ones.
  always_comb begin
    for (int k = 0; k < NCLS; k++) begin
      cnt_d[k] = cnt_q[k];
    end
    if (cnt_clear) begin
      for (int k = 0; k < NCLS; k++) begin
        cnt_d[k] = '0;
      end
    end else if (rsp_fire && (cnt_q[rsp_class_q] != '1)) begin
      cnt_d[rsp_class_q] = cnt_q[rsp_class_q] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NCLS; k++) begin
      if (!rst_n) begin
        cnt_q[k] <= '0;
      end else begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  for (genvar g = 0; g < NCLS; g++) begin : g_cnt_out
    assign class_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule
